// File: rtl/pll_reconfig_sequencer.sv
// Sequences an M/N reconfiguration of the tester clock PLL through the reconfig core,
// then supervises lock with timeout and areset-based retry.
module pll_reconfig_sequencer #(
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int LOCK_STABLE   = 16,
    parameter int ARESET_CYCLES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_mult,
    input  logic [7:0] req_div,
    output logic       done,
    output logic [1:0] err_code,
    output logic [7:0] cur_mult,
    output logic [7:0] cur_div,
    input  logic       rcfg_busy,
    output logic [3:0] rcfg_counter_type,
    output logic [2:0] rcfg_counter_param,
    output logic [8:0] rcfg_data_in,
    output logic       rcfg_write_param,
    output logic       rcfg_reconfig,
    input  logic       pll_locked,
    output logic       pll_areset
);

    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam int AW = $clog2(ARESET_CYCLES) + 1;
    localparam int RW = $clog2(MAX_RETRY) + 1;

    typedef enum logic [3:0] {
        IDLE, CHECK, WRITE, WAIT_WR, RECONF, WAIT_RC, LOCK_WAIT, ARESET, FIN
    } state_t;

    state_t        state;
    logic [7:0]    mult_q, div_q;
    logic [2:0]    idx;
    logic          wait_min;
    logic [TW-1:0] timeout_cnt, timeout_next;
    logic [SW-1:0] stable_cnt, stable_next;
    logic [AW-1:0] areset_cnt;
    logic [RW-1:0] retries;
    logic          locked_meta, locked_sync;

    logic [2:0]    load_idx;
    logic [7:0]    load_val;
    logic [3:0]    load_type;
    logic [2:0]    load_param;
    logic [8:0]    load_data;

    // high/low split of a divide factor across the counter's two half-periods
    function automatic logic [8:0] field_value(input logic [7:0] v, input logic [1:0] sel);
        logic [8:0] w;
        w = {1'b0, v};
        case (sel)
            2'd0:    return (w + 9'd1) >> 1;
            2'd1:    return w >> 1;
            2'd2:    return {8'd0, v == 8'd1};
            default: return {8'd0, v[0]};
        endcase
    endfunction

    // Fields for the write about to be issued: index 0 from CHECK, idx+1 from WAIT_WR
    always_comb begin
        load_idx   = (state == CHECK) ? 3'd0 : idx + 3'd1;
        load_val   = load_idx[2] ? div_q : mult_q;
        load_type  = load_idx[2] ? 4'b0000 : 4'b0001;
        case (load_idx[1:0])
            2'd0:    load_param = 3'b000;
            2'd1:    load_param = 3'b001;
            2'd2:    load_param = 3'b100;
            default: load_param = 3'b101;
        endcase
        load_data    = field_value(load_val, load_idx[1:0]);
        stable_next  = locked_sync ? stable_cnt + SW'(1) : '0;
        timeout_next = timeout_cnt + TW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            req_ready          <= 1'b1;
            done               <= 1'b0;
            err_code           <= 2'b00;
            cur_mult           <= 8'd1;
            cur_div            <= 8'd1;
            rcfg_counter_type  <= '0;
            rcfg_counter_param <= '0;
            rcfg_data_in       <= '0;
            rcfg_write_param   <= 1'b0;
            rcfg_reconfig      <= 1'b0;
            pll_areset         <= 1'b0;
            mult_q             <= '0;
            div_q              <= '0;
            idx                <= '0;
            wait_min           <= 1'b0;
            timeout_cnt        <= '0;
            stable_cnt         <= '0;
            areset_cnt         <= '0;
            retries            <= '0;
        end else begin
            // NOTE: strobes default low here so every pulse lasts exactly one cycle.
            done             <= 1'b0;
            rcfg_write_param <= 1'b0;
            rcfg_reconfig    <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    mult_q    <= req_mult;
                    div_q     <= req_div;
                    req_ready <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: if (mult_q == 8'd0 || div_q == 8'd0) begin
                    err_code <= 2'b01;
                    done     <= 1'b1;
                    state    <= FIN;
                end else begin
                    idx                <= 3'd0;
                    rcfg_counter_type  <= load_type;
                    rcfg_counter_param <= load_param;
                    rcfg_data_in       <= load_data;
                    rcfg_write_param   <= 1'b1;
                    state              <= WRITE;
                end
                WRITE: begin
                    wait_min <= 1'b0;
                    state    <= WAIT_WR;
                end
                WAIT_WR: if (!wait_min) begin
                    wait_min <= 1'b1;
                end else if (!rcfg_busy) begin
                    if (idx != 3'd7) begin
                        idx                <= load_idx;
                        rcfg_counter_type  <= load_type;
                        rcfg_counter_param <= load_param;
                        rcfg_data_in       <= load_data;
                        rcfg_write_param   <= 1'b1;
                        state              <= WRITE;
                    end else begin
                        rcfg_reconfig <= 1'b1;
                        state         <= RECONF;
                    end
                end
                RECONF: begin
                    wait_min <= 1'b0;
                    state    <= WAIT_RC;
                end
                WAIT_RC: if (!wait_min) begin
                    wait_min <= 1'b1;
                end else if (!rcfg_busy) begin
                    timeout_cnt <= '0;
                    stable_cnt  <= '0;
                    retries     <= '0;
                    state       <= LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    stable_cnt  <= stable_next;
                    timeout_cnt <= timeout_next;
                    if (stable_next == SW'(LOCK_STABLE)) begin
                        cur_mult <= mult_q;
                        cur_div  <= div_q;
                        err_code <= 2'b00;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else if (timeout_next == TW'(LOCK_TIMEOUT)) begin
                        if (retries < RW'(MAX_RETRY)) begin
                            retries    <= retries + RW'(1);
                            areset_cnt <= '0;
                            pll_areset <= 1'b1;
                            state      <= ARESET;
                        end else begin
                            err_code <= 2'b10;
                            done     <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end
                ARESET: if (areset_cnt == AW'(ARESET_CYCLES - 1)) begin
                    pll_areset  <= 1'b0;
                    timeout_cnt <= '0;
                    stable_cnt  <= '0;
                    state       <= LOCK_WAIT;
                end else begin
                    areset_cnt <= areset_cnt + AW'(1);
                end
                FIN: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Table-driven bench for pll_reconfig_sequencer with behavioural models of the
// reconfig core busy line and the PLL lock output.
module tb_pll_reconfig_sequencer;

    localparam int LOCK_TIMEOUT  = 4096;
    localparam int LOCK_STABLE   = 16;
    localparam int ARESET_CYCLES = 8;
    localparam int MAX_RETRY     = 3;
    localparam int M_RISE = 0, M_LOW = 1, M_TOGGLE = 2;

    logic       clock, reset;
    logic       req_valid, req_ready;
    logic [7:0] req_mult, req_div;
    logic       done;
    logic [1:0] err_code;
    logic [7:0] cur_mult, cur_div;
    logic       rcfg_busy;
    logic [3:0] rcfg_counter_type;
    logic [2:0] rcfg_counter_param;
    logic [8:0] rcfg_data_in;
    logic       rcfg_write_param, rcfg_reconfig;
    logic       pll_locked, pll_areset;

    pll_reconfig_sequencer #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
        .ARESET_CYCLES(ARESET_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mult(req_mult), .req_div(req_div),
        .done(done), .err_code(err_code),
        .cur_mult(cur_mult), .cur_div(cur_div),
        .rcfg_busy(rcfg_busy),
        .rcfg_counter_type(rcfg_counter_type), .rcfg_counter_param(rcfg_counter_param),
        .rcfg_data_in(rcfg_data_in), .rcfg_write_param(rcfg_write_param),
        .rcfg_reconfig(rcfg_reconfig),
        .pll_locked(pll_locked), .pll_areset(pll_areset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] mult;
        logic [7:0] div;
        int         mode;
        bit         hold_valid;
        logic [1:0] err;
        logic [7:0] cur_m;
        logic [7:0] cur_d;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          mode = M_RISE;
    int          n_wr, n_rc, n_ar, n_done, ready_leak;
    logic [15:0] wr_log [16];
    int          ar_start [8], ar_end [8];
    int          done_cyc, rise_cyc, acc_cyc;
    logic [1:0]  done_err;
    bit          in_seq = 0, areset_prev = 0, tg_active = 0;
    int          busy_cnt = 0, lk_timer = 0, tg_phase = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected {type, param, data} for write slot i of a request
    function automatic logic [15:0] exp_write(input logic [7:0] m, input logic [7:0] d, input int i);
        int v, p, data;
        logic [3:0] typ;
        logic [2:0] par;
        v   = (i < 4) ? int'(m) : int'(d);
        typ = (i < 4) ? 4'd1 : 4'd0;
        p   = i % 4;
        par = (p == 0) ? 3'd0 : (p == 1) ? 3'd1 : (p == 2) ? 3'd4 : 3'd5;
        data = (p == 0) ? (v + 1) / 2 : (p == 1) ? v / 2 : (p == 2) ? int'(v == 1) : v % 2;
        return {typ, par, 9'(data)};
    endfunction

    // Monitor plus reconfig-core and PLL models, all away from the active edge
    always @(negedge clock) begin
        cyc++;
        if (rcfg_write_param && n_wr < 16) begin
            wr_log[n_wr] = {rcfg_counter_type, rcfg_counter_param, rcfg_data_in};
            n_wr++;
        end
        if (rcfg_reconfig) n_rc++;
        if (pll_areset && !areset_prev && n_ar < 8) ar_start[n_ar] = cyc;
        if (!pll_areset && areset_prev && n_ar < 8) begin
            ar_end[n_ar] = cyc;
            n_ar++;
        end
        areset_prev = pll_areset;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_err = err_code;
        end
        if (in_seq && req_ready) ready_leak++;

        if (busy_cnt > 0) busy_cnt--;
        if (rcfg_write_param || rcfg_reconfig) busy_cnt = 3;
        rcfg_busy = (busy_cnt > 0);

        if (mode == M_RISE) begin
            if (rcfg_reconfig) lk_timer = 20;
            else if (lk_timer > 0) begin
                lk_timer--;
                if (lk_timer == 0) pll_locked = 1'b1;
            end
        end else if (mode == M_TOGGLE) begin
            if (rcfg_reconfig) begin
                tg_active  = 1;
                tg_phase   = 0;
                pll_locked = 1'b1;
            end else if (tg_active) begin
                tg_phase++;
                if (tg_phase >= 55) begin
                    rise_cyc   = cyc;
                    pll_locked = 1'b1;
                    tg_active  = 0;
                end else begin
                    pll_locked = (tg_phase % 11 != 10);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_strobes"}, {rcfg_write_param, rcfg_reconfig, pll_areset}, 0);
        check({tag, "_rcfg_fields"}, {rcfg_counter_type, rcfg_counter_param, rcfg_data_in}, 0);
        check({tag, "_cur"}, {cur_mult, cur_div}, {8'd1, 8'd1});
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int k;
        n_wr = 0; n_rc = 0; n_ar = 0; n_done = 0; ready_leak = 0;
        lk_timer = 0; tg_active = 0; rise_cyc = 0;
        pll_locked = 1'b0;
        mode = v.mode;
        for (k = 0; k < 100 && !req_ready; k++) @(negedge clock);
        check({tag, "_ready_before"}, req_ready, 1);
        @(negedge clock);
        req_valid = 1'b1;
        req_mult  = v.mult;
        req_div   = v.div;
        acc_cyc   = cyc;
        @(posedge clock);
        #1 in_seq = 1;
        if (!v.hold_valid) req_valid = 1'b0;
        for (k = 0; k < 20000 && n_done == 0; k++) @(posedge clock);
        #1;
        req_valid = 1'b0;
        in_seq    = 0;
        if (n_done == 0) begin
            check({tag, "_done_timeout"}, 0, 1);
            return;
        end
        check({tag, "_err"}, done_err, v.err);
        check({tag, "_cur"}, {cur_mult, cur_div}, {v.cur_m, v.cur_d});
        check({tag, "_n_writes"}, n_wr, (v.err == 2'b01) ? 0 : 8);
        check({tag, "_n_reconfig"}, n_rc, (v.err == 2'b01) ? 0 : 1);
        for (int i = 0; i < 8 && i < n_wr; i++)
            check($sformatf("%s_write%0d", tag, i), wr_log[i], exp_write(v.mult, v.div, i));
        if (v.err == 2'b01) check({tag, "_bad_param_latency"}, (done_cyc - acc_cyc) <= 3, 1);
        if (v.mode == M_LOW) begin
            check({tag, "_n_areset"}, n_ar, MAX_RETRY);
            for (int i = 0; i < 3 && i < n_ar; i++)
                check($sformatf("%s_areset_width%0d", tag, i), ar_end[i] - ar_start[i], ARESET_CYCLES);
            for (int i = 0; i < 2 && i + 1 < n_ar; i++)
                check($sformatf("%s_areset_gap%0d", tag, i), ar_start[i+1] - ar_end[i], LOCK_TIMEOUT);
        end else begin
            check({tag, "_n_areset"}, n_ar, 0);
        end
        if (v.mode == M_TOGGLE) begin
            // 2 synchroniser cycles plus 16 consecutive high samples after the last rise
            check({tag, "_stable_delay"}, done_cyc - rise_cyc, 18);
            check({tag, "_ready_held_low"}, ready_leak, 0);
        end
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_err_hold"}, err_code, v.err);
        check({tag, "_single_done"}, n_done, 1);
        check({tag, "_idle_ready"}, req_ready, 1);
    endtask

    vec_t        vecs [7];
    logic [15:0] hand_writes [8];

    initial begin
        vecs[0] = '{8'd5,   8'd2, M_RISE,   1'b0, 2'b00, 8'd5,   8'd2};
        vecs[1] = '{8'd1,   8'd1, M_RISE,   1'b0, 2'b00, 8'd1,   8'd1};
        vecs[2] = '{8'd0,   8'd4, M_RISE,   1'b0, 2'b01, 8'd1,   8'd1};
        vecs[3] = '{8'd255, 8'd7, M_RISE,   1'b0, 2'b00, 8'd255, 8'd7};
        vecs[4] = '{8'd3,   8'd0, M_RISE,   1'b0, 2'b01, 8'd255, 8'd7};
        vecs[5] = '{8'd9,   8'd6, M_LOW,    1'b0, 2'b10, 8'd255, 8'd7};
        vecs[6] = '{8'd4,   8'd3, M_TOGGLE, 1'b1, 2'b00, 8'd4,   8'd3};
        hand_writes = '{{4'd1, 3'd0, 9'd3}, {4'd1, 3'd1, 9'd2}, {4'd1, 3'd4, 9'd0}, {4'd1, 3'd5, 9'd1},
                        {4'd0, 3'd0, 9'd1}, {4'd0, 3'd1, 9'd1}, {4'd0, 3'd4, 9'd0}, {4'd0, 3'd5, 9'd0}};

        reset = 1'b0; req_valid = 1'b0; req_mult = '0; req_div = '0;
        rcfg_busy = 1'b0; pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
            if (i == 0)
                for (int j = 0; j < 8; j++)
                    check($sformatf("m5n2_hand_write%0d", j), wr_log[j], hand_writes[j]);
        end

        // Reset while waiting on the first parameter write
        n_wr = 0; n_done = 0; mode = M_RISE; pll_locked = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_mult = 8'd6; req_div = 8'd5;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 50 && n_wr == 0; k++) @(posedge clock);
        check("midreset_write_seen", n_wr, 1);
        #2 reset = 1'b0;
        #1 check_reset_values("midreset");
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("midreset_no_done", n_done, 0);
        run_vector('{8'd6, 8'd5, M_RISE, 1'b0, 2'b00, 8'd6, 8'd5}, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_sequencer.md
Name: pll_reconfig_sequencer

Overview:
- Sequences a dynamic reconfiguration of the tester clock PLL through the PLL reconfiguration core.
- Accepts one multiply/divide request at a time over a valid/ready handshake and computes the M and N counter fields.
- Issues the parameter writes, triggers reconfig, then supervises lock with timeout and areset-retry.
- Sits between the test-sequencer register interface and the PLL reconfiguration core.

Parameters:
LOCK_TIMEOUT, 4096, max cycles to wait for stable lock per attempt
LOCK_STABLE, 16, consecutive cycles locked must be high to count as locked
ARESET_CYCLES, 8, width of pll_areset pulse on retry
MAX_RETRY, 3, areset retries before failure

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset (low = reset)
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when valid&ready
req_mult  in  8  M factor
req_div  in  8  N factor
done  out  1  one-cycle completion pulse
err_code  out  2  valid with done: 00 ok, 01 bad parameter, 10 lock failure
cur_mult  out  8  last successfully applied M
cur_div  out  8  last successfully applied N
rcfg_busy  in  1  reconfig core busy
rcfg_counter_type  out  4  0000 = N counter, 0001 = M counter
rcfg_counter_param  out  3  000 high, 001 low, 100 bypass, 101 odd
rcfg_data_in  out  9  parameter value
rcfg_write_param  out  1  one-cycle write strobe
rcfg_reconfig  out  1  one-cycle reconfig strobe
pll_locked  in  1  PLL lock, asynchronous; double-flop synchronised internally
pll_areset  out  1  PLL reset request

Behaviour:
- Reset values:
  - state IDLE, req_ready=1.
  - done, err_code, strobes and pll_areset = 0.
  - rcfg_counter_type, rcfg_counter_param, rcfg_data_in = 0.
  - cur_mult = cur_div = 1.
- Reset mid-operation abandons the sequence; no done is issued.
- States: IDLE, CHECK, WRITE, WAIT_WR, RECONF, WAIT_RC, LOCK_WAIT, ARESET, FIN.
- IDLE:
  - On req_valid&req_ready, latch mult/div and go to CHECK.
  - req_ready is 1 only in IDLE.
- CHECK:
  - If mult==0 or div==0: go to FIN with err_code=01; no rcfg strobe issued.
  - Else clear the write index (0..7) and go to WRITE.
- Write index order:
  - 0..3 target M (type 0001), 4..7 target N (type 0000).
  - Within each counter, params in order high, low, bypass, odd.
- Field values for value v, zero-extended to 9 bits:
  - high = (v+1)>>1, low = v>>1.
  - bypass = (v==1), odd = v[0].
  - Example: v=5 gives 3, 2, 0, 1. Example: v=255 gives 128, 127, 0, 1.
- WRITE:
  - Type, param and data are driven stable; rcfg_write_param=1 for exactly one cycle.
  - Go to WAIT_WR.
  - Type/param/data hold until the next WRITE.
- WAIT_WR:
  - Minimum 2 cycles, to tolerate 1-cycle busy-rise latency.
  - Exit on the first cycle at or after the 2nd with rcfg_busy==0.
  - If index<7: increment the index and go to WRITE. Else go to RECONF.
- RECONF: rcfg_reconfig=1 for one cycle, then WAIT_RC (same 2-cycle minimum and busy rule as WAIT_WR).
- LOCK_WAIT:
  - Timeout counter runs from 0; stable counter counts consecutive synchronised-locked cycles.
  - Stable counter clears on any low sample.
  - Stable counter reaching LOCK_STABLE: FIN with err_code=00, and cur_mult/cur_div updated in the same cycle.
  - Timeout counter reaching LOCK_TIMEOUT (checked after the stable condition, so stable wins on a tie):
    - If retries<MAX_RETRY: increment retries and go to ARESET.
    - Else: FIN with err_code=10.
- ARESET:
  - pll_areset=1 for ARESET_CYCLES cycles.
  - Then LOCK_WAIT with both counters cleared; the retry count is kept.
- FIN: done=1 for one cycle, err_code valid that cycle, then IDLE.
- err_code holds its value until the next FIN.
- A new request is never accepted in the FIN cycle (req_ready=0).
- Counter widths are sized by clog2 of their parameter +1; no wrap is possible.

Test Plan:
- Request M=5, N=2, busy high 3 cycles per op, locked rises 20 cycles after reconfig:
  - Writes in order (0001,000,3)(0001,001,2)(0001,100,0)(0001,101,1)(0000,000,1)(0000,001,1)(0000,100,0)(0000,101,0).
  - One reconfig pulse, then done with err=00, cur_mult=5, cur_div=2.
- M=1, N=1: bypass writes carry data 1, high=1, low=0; done err=00.
- M=0, N=4: done within 3 cycles of acceptance, err=01, zero write_param/reconfig pulses, cur_* unchanged.
- locked held low:
  - Exactly 3 areset pulses of 8 cycles each, spaced LOCK_TIMEOUT apart.
  - Then done err=10; cur_* unchanged.
- locked toggles high 10 cycles / low 1 cycle, then steady high:
  - Done only after 16 consecutive high samples.
  - req_valid held during the whole sequence is not accepted until IDLE.
- reset driven low while in WAIT_WR: all outputs return to reset values immediately, no done; the next request completes normally.
